// File: rtl/frogger_game_controller_pkg.sv
// Shared definitions for the Frogger game sequencer: state codes,
// default timing/level constants and the car speed helper.
package frogger_game_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_HIT       = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  localparam int DEF_LIVES_INI       = 3;
  localparam int DEF_MAX_LEVEL       = 9;
  localparam int DEF_BASE_CAR_SPEED  = 1;
  localparam int DEF_SPEED_STEP      = 1;
  localparam int DEF_DEATH_FRAMES    = 60;
  localparam int DEF_LEVEL_FRAMES    = 90;
  localparam int DEF_GAMEOVER_FRAMES = 180;

  // Linear speed ramp per level, clamped to the 4-bit speed range.
  function automatic logic [3:0] calc_speed(input int base, input int step,
                                            input logic [3:0] level);
    int s;
    s = base + step * (int'(level) - 1);
    if (s > 15) return 4'd15;
    if (s < 0) return 4'd0;
    return 4'(s);
  endfunction

endpackage

// File: rtl/frogger_game_controller_frame_timer.sv
// Counts frame ticks since the last clear; o_Done flags the tick that
// brings the count up to i_Limit.
module frogger_game_controller_frame_timer (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Clear,
  input  logic       i_Tick,
  input  logic [7:0] i_Limit,
  output logic       o_Done
);

  logic [7:0] count_q, count_d;

  // Clear wins over a coincident tick so the entry cycle is never counted.
  always_comb begin
    count_d = count_q;
    if (i_Clear) begin
      count_d = '0;
    end else if (i_Tick) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_Done = i_Tick && (({1'b0, count_q} + 9'd1) >= {1'b0, i_Limit});

endmodule

// File: rtl/frogger_game_controller.sv
// Frogger game sequencer: game FSM, lives/level bookkeeping, car speed
// per level and the frog re-spawn pulse, paced by the frame tick.
module frogger_game_controller
  import frogger_game_controller_pkg::*;
#(
  parameter int c_LIVES_INI       = DEF_LIVES_INI,
  parameter int c_MAX_LEVEL       = DEF_MAX_LEVEL,
  parameter int c_BASE_CAR_SPEED  = DEF_BASE_CAR_SPEED,
  parameter int c_SPEED_STEP      = DEF_SPEED_STEP,
  parameter int c_DEATH_FRAMES    = DEF_DEATH_FRAMES,
  parameter int c_LEVEL_FRAMES    = DEF_LEVEL_FRAMES,
  parameter int c_GAMEOVER_FRAMES = DEF_GAMEOVER_FRAMES
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic       i_Has_Collided,
  input  logic       i_Frog_At_Goal,
  output logic [2:0] o_Game_State,
  output logic [2:0] o_Lives,
  output logic [3:0] o_Level,
  output logic [3:0] o_Car_Speed,
  output logic       o_Cars_Enable,
  output logic       o_Frog_Reset,
  output logic       o_Frog_Enable
);

  localparam logic [2:0] LIVES_INI  = 3'(c_LIVES_INI);
  localparam logic [3:0] MAX_LEVEL  = 4'(c_MAX_LEVEL);
  localparam logic [3:0] BASE_SPEED = 4'(c_BASE_CAR_SPEED);
  localparam logic [7:0] DEATH_LIM  = 8'(c_DEATH_FRAMES);
  localparam logic [7:0] LEVEL_LIM  = 8'(c_LEVEL_FRAMES);
  localparam logic [7:0] OVER_LIM   = 8'(c_GAMEOVER_FRAMES);

  logic [2:0] state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [3:0] level_q, level_d;
  logic [3:0] speed_q, speed_d;
  logic       cars_en_q, cars_en_d;
  logic       frog_en_q, frog_en_d;
  logic       frog_rst_q, frog_rst_d;
  logic       start_prev_q;
  logic       start_edge;
  logic       timer_clear;
  logic       timer_done;
  logic [7:0] timer_limit;

  assign start_edge  = i_Start && !start_prev_q;
  assign timer_clear = (state_d != state_q);

  always_comb begin
    case (state_q)
      ST_HIT:      timer_limit = DEATH_LIM;
      ST_LEVEL_UP: timer_limit = LEVEL_LIM;
      default:     timer_limit = OVER_LIM;
    endcase
  end

  frogger_game_controller_frame_timer u_frame_timer (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Clear (timer_clear),
    .i_Tick  (i_Frame_Tick),
    .i_Limit (timer_limit),
    .o_Done  (timer_done)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= ST_IDLE;
      lives_q      <= LIVES_INI;
      level_q      <= 4'd1;
      speed_q      <= BASE_SPEED;
      cars_en_q    <= 1'b1;
      frog_en_q    <= 1'b0;
      frog_rst_q   <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      speed_q      <= speed_d;
      cars_en_q    <= cars_en_d;
      frog_en_q    <= frog_en_d;
      frog_rst_q   <= frog_rst_d;
      start_prev_q <= i_Start;
    end
  end

  // Collision and goal are only acted on while playing; collision has priority.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          lives_d = LIVES_INI;
          level_d = 4'd1;
          state_d = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (i_Has_Collided) begin
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
            state_d = ST_HIT;
          end else begin
            lives_d = 3'd0;
            state_d = ST_GAME_OVER;
          end
        end else if (i_Frog_At_Goal) begin
          level_d = (level_q >= MAX_LEVEL) ? MAX_LEVEL : level_q + 4'd1;
          state_d = ST_LEVEL_UP;
        end
      end
      ST_HIT, ST_LEVEL_UP: begin
        if (timer_done) state_d = ST_PLAYING;
      end
      ST_GAME_OVER: begin
        if (timer_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs follow the upcoming state so they line up with o_Game_State.
  always_comb begin
    cars_en_d  = (state_d == ST_IDLE) || (state_d == ST_PLAYING);
    frog_en_d  = (state_d == ST_PLAYING);
    frog_rst_d = (state_d == ST_PLAYING) && (state_q != ST_PLAYING);
    speed_d    = calc_speed(c_BASE_CAR_SPEED, c_SPEED_STEP, level_q);
  end

  assign o_Game_State  = state_q;
  assign o_Lives       = lives_q;
  assign o_Level       = level_q;
  assign o_Car_Speed   = speed_q;
  assign o_Cars_Enable = cars_en_q;
  assign o_Frog_Reset  = frog_rst_q;
  assign o_Frog_Enable = frog_en_q;

endmodule

// File: tb/tb_frogger_game_controller.sv
// Bench for frogger_game_controller: a game-rules model checked every cycle
// against two instances (speed step 1 and 2) plus directed literal checks.
module tb_frogger_game_controller;

  localparam int DEATH_F = 4;
  localparam int LEVEL_F = 3;
  localparam int OVER_F  = 5;
  localparam int MAXLVL  = 9;
  localparam int LIVES0  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic coll = 1'b0;
  logic goal = 1'b0;

  logic [2:0] st1, lv1, st2, lv2;
  logic [3:0] lvl1, spd1, lvl2, spd2;
  logic       cars1, frst1, fen1, cars2, frst2, fen2;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int p0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  frogger_game_controller #(
    .c_LIVES_INI(LIVES0), .c_MAX_LEVEL(MAXLVL), .c_BASE_CAR_SPEED(1),
    .c_SPEED_STEP(1), .c_DEATH_FRAMES(DEATH_F), .c_LEVEL_FRAMES(LEVEL_F),
    .c_GAMEOVER_FRAMES(OVER_F)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Tick(tick), .i_Start(start),
    .i_Has_Collided(coll), .i_Frog_At_Goal(goal),
    .o_Game_State(st1), .o_Lives(lv1), .o_Level(lvl1), .o_Car_Speed(spd1),
    .o_Cars_Enable(cars1), .o_Frog_Reset(frst1), .o_Frog_Enable(fen1)
  );

  frogger_game_controller #(
    .c_LIVES_INI(LIVES0), .c_MAX_LEVEL(MAXLVL), .c_BASE_CAR_SPEED(1),
    .c_SPEED_STEP(2), .c_DEATH_FRAMES(DEATH_F), .c_LEVEL_FRAMES(LEVEL_F),
    .c_GAMEOVER_FRAMES(OVER_F)
  ) dut2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Tick(tick), .i_Start(start),
    .i_Has_Collided(coll), .i_Frog_At_Goal(goal),
    .o_Game_State(st2), .o_Lives(lv2), .o_Level(lvl2), .o_Car_Speed(spd2),
    .o_Cars_Enable(cars2), .o_Frog_Reset(frst2), .o_Frog_Enable(fen2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- game-rules model ----------------
  int m_state, m_lives, m_level, m_spd1, m_spd2, m_ticks, m_next, m_dur;
  bit m_cars, m_frog, m_pulse, m_prev, m_edge;

  function automatic int speed_of(input int step, input int lvl);
    int s;
    s = 1 + step * (lvl - 1);
    return (s > 15) ? 15 : s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_lives = LIVES0; m_level = 1; m_spd1 = 1; m_spd2 = 1;
      m_ticks = 0; m_cars = 1'b1; m_frog = 1'b0; m_pulse = 1'b0; m_prev = 1'b0;
    end else begin
      m_edge = start && !m_prev;
      m_prev = start;
      m_spd1 = speed_of(1, m_level);
      m_spd2 = speed_of(2, m_level);
      m_next = m_state;
      m_dur  = (m_state == 2) ? DEATH_F : (m_state == 3) ? LEVEL_F : OVER_F;
      if (m_state == 0) begin
        if (m_edge) begin m_lives = LIVES0; m_level = 1; m_next = 1; end
      end else if (m_state == 1) begin
        if (coll) begin
          m_lives = (m_lives > 1) ? m_lives - 1 : 0;
          m_next  = (m_lives > 0) ? 2 : 4;
        end else if (goal) begin
          m_level = (m_level < MAXLVL) ? m_level + 1 : MAXLVL;
          m_next  = 3;
        end
      end else if (tick && (m_ticks + 1 >= m_dur)) begin
        m_next = (m_state == 4) ? 0 : 1;
      end
      if (tick) m_ticks++;
      if (m_next != m_state) m_ticks = 0;
      m_pulse = (m_next == 1) && (m_state != 1);
      m_state = m_next;
      m_cars  = (m_state == 0) || (m_state == 1);
      m_frog  = (m_state == 1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state", 32'(st1), 32'(m_state));
      check("lives", 32'(lv1), 32'(m_lives));
      check("level", 32'(lvl1), 32'(m_level));
      check("speed", 32'(spd1), 32'(m_spd1));
      check("cars_en", 32'(cars1), 32'(m_cars));
      check("frog_en", 32'(fen1), 32'(m_frog));
      check("frog_reset", 32'(frst1), 32'(m_pulse));
      check("state_s2", 32'(st2), 32'(m_state));
      check("lives_s2", 32'(lv2), 32'(m_lives));
      check("level_s2", 32'(lvl2), 32'(m_level));
      check("speed_s2", 32'(spd2), 32'(m_spd2));
      check("cars_en_s2", 32'(cars2), 32'(m_cars));
      check("frog_en_s2", 32'(fen2), 32'(m_frog));
      check("frog_reset_s2", 32'(frst2), 32'(m_pulse));
    end
    if (rst_n && frst1) pulses++;
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(1);
    end
  endtask

  initial begin
    cyc(3);
    chk_en = 1'b1;
    check("rst_state", 32'(st1), 0);
    check("rst_lives", 32'(lv1), 3);
    check("rst_level", 32'(lvl1), 1);
    check("rst_speed", 32'(spd1), 1);
    check("rst_cars", 32'(cars1), 1);
    check("rst_frog_en", 32'(fen1), 0);
    check("rst_frog_reset", 32'(frst1), 0);
    rst_n = 1'b1;
    cyc(2);

    start = 1'b1; cyc(1);
    $display("[TB] start edge: state=%0d lives=%0d level=%0d", st1, lv1, lvl1);
    check("start_state", 32'(st1), 1);
    check("start_lives", 32'(lv1), 3);
    check("start_pulse", 32'(frst1), 1);
    start = 1'b0; cyc(1);
    check("start_pulse_end", 32'(frst1), 0);
    check("start_pulse_count", 32'(pulses), 1);

    coll = 1'b1; cyc(1); coll = 1'b0;
    $display("[TB] collision: state=%0d lives=%0d", st1, lv1);
    check("hit_state", 32'(st1), 2);
    check("hit_lives", 32'(lv1), 2);
    p0 = pulses;
    frames(3);
    check("hit_wait", 32'(st1), 2);
    frames(1);
    $display("[TB] hit over: state=%0d", st1);
    check("hit_done", 32'(st1), 1);
    check("hit_pulse", 32'(pulses - p0), 1);

    for (int i = 0; i < 10; i++) begin
      goal = 1'b1; cyc(1); goal = 1'b0;
      $display("[TB] goal %0d: state=%0d level=%0d", i, st1, lvl1);
      check("goal_state", 32'(st1), 3);
      check("goal_level", 32'(lvl1), 32'((i + 2 > 9) ? 9 : i + 2));
      frames(3);
      check("goal_back", 32'(st1), 1);
    end
    cyc(1);
    check("speed_sat_step1", 32'(spd1), 9);
    check("speed_sat_step2", 32'(spd2), 15);

    coll = 1'b1; goal = 1'b1; cyc(1); coll = 1'b0; goal = 1'b0;
    $display("[TB] collision+goal: state=%0d lives=%0d level=%0d", st1, lv1, lvl1);
    check("both_state", 32'(st1), 2);
    check("both_lives", 32'(lv1), 1);
    check("both_level", 32'(lvl1), 9);
    frames(4);
    check("both_back", 32'(st1), 1);

    coll = 1'b1; cyc(1); coll = 1'b0;
    $display("[TB] last life: state=%0d lives=%0d", st1, lv1);
    check("over_state", 32'(st1), 4);
    check("over_lives", 32'(lv1), 0);
    coll = 1'b1; cyc(2); coll = 1'b0;
    start = 1'b1;
    frames(4);
    check("over_wait", 32'(st1), 4);
    frames(1);
    $display("[TB] game over done: state=%0d lives=%0d level=%0d", st1, lv1, lvl1);
    check("idle_state", 32'(st1), 0);
    check("idle_lives_hold", 32'(lv1), 0);
    check("idle_level_hold", 32'(lvl1), 9);
    cyc(5);
    check("no_restart_held", 32'(st1), 0);
    start = 1'b0; cyc(1);
    start = 1'b1; cyc(1);
    $display("[TB] restart: state=%0d lives=%0d level=%0d", st1, lv1, lvl1);
    check("restart_state", 32'(st1), 1);
    check("restart_lives", 32'(lv1), 3);
    check("restart_level", 32'(lvl1), 1);
    cyc(1);
    check("restart_speed", 32'(spd1), 1);
    start = 1'b0;

    goal = 1'b1; cyc(1); goal = 1'b0;
    check("lu_state", 32'(st1), 3);
    check("lu_level", 32'(lvl1), 2);
    frames(1);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    $display("[TB] async reset in LEVEL_UP: state=%0d lives=%0d level=%0d", st1, lv1, lvl1);
    check("ar_state", 32'(st1), 0);
    check("ar_lives", 32'(lv1), 3);
    check("ar_level", 32'(lvl1), 1);
    check("ar_speed", 32'(spd1), 1);
    check("ar_cars", 32'(cars1), 1);
    check("ar_frog_en", 32'(fen1), 0);
    p0 = pulses;
    tick = 1'b1; cyc(3); tick = 1'b0;
    rst_n = 1'b1;
    frames(4);
    check("ar_no_pulse", 32'(pulses - p0), 0);
    check("ar_idle", 32'(st1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
